// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares one single-port word memory between two requesters:
//   port 0 (instruction fetch) and port 1 (load/store unit).
//   Each access takes two cycles.
//   - Issue cycle (IDLE): the winner's request is driven combinationally
//     onto the memory port.
//   - Ack cycle (BUSY): the granted requester sees a one-cycle ack, with
//     the memory's registered read data passed straight through.
//   Ties are broken round-robin, or in favour of port 0 when PRIO_FIXED=1.
//
// Ports
//   clk, reset           system clock; synchronous active-high reset
//   m0_addr/wdata/wmask  port 0 request (wmask == 0 means read)
//   m0_req               port 0 request, held stable until m0_ack
//   m0_ack, m0_rdata     port 0 completion pulse and read data
//   m1_*                 same set as m0_* for port 1
//   mem_addr/wdata       memory byte address and write data
//   mem_wmask            memory byte write enables
//   mem_rstrb            memory read strobe
//   mem_rdata            memory read data, valid one cycle after mem_rstrb
module mem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter bit PRIO_FIXED = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [31:0]           m0_wdata,
  input  logic [3:0]            m0_wmask,
  input  logic                  m0_req,
  output logic                  m0_ack,
  output logic [31:0]           m0_rdata,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [31:0]           m1_wdata,
  input  logic [3:0]            m1_wmask,
  input  logic                  m1_req,
  output logic                  m1_ack,
  output logic [31:0]           m1_rdata,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_rstrb,
  output logic [31:0]           mem_wdata,
  output logic [3:0]            mem_wmask,
  input  logic [31:0]           mem_rdata
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t state_p1;
  logic   grant_p1;
  logic   last_p1;

  logic       any_req;
  logic       win;
  logic       issue;
  logic [3:0] sel_wmask;
  logic       busy_ok;

  always_comb begin
    any_req = m0_req | m1_req;
    if (m0_req && m1_req) begin
      win = PRIO_FIXED ? 1'b0 : ~last_p1;
    end else begin
      win = m1_req;
    end
  end

  // Issue stage: the winner drives the memory port directly.
  assign issue     = (state_p1 == IDLE) && any_req;
  assign sel_wmask = win ? m1_wmask : m0_wmask;
  assign mem_addr  = win ? m1_addr  : m0_addr;
  assign mem_wdata = win ? m1_wdata : m0_wdata;
  assign mem_wmask = issue ? sel_wmask : 4'b0000;
  assign mem_rstrb = issue && (sel_wmask == 4'b0000);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_p1 <= IDLE;
      grant_p1 <= 1'b0;
      last_p1  <= 1'b1;
    end else begin
      case (state_p1)
        IDLE: begin
          if (any_req) begin
            grant_p1 <= win;
            last_p1  <= win;
            state_p1 <= BUSY;
          end
        end
        default: state_p1 <= IDLE;
      endcase
    end
  end

  // Ack stage: one-cycle ack to the granted port.
  // Reset also masks the ack, so an access caught in flight is never acknowledged.
  assign busy_ok  = (state_p1 == BUSY) && !reset;
  assign m0_ack   = busy_ok && !grant_p1;
  assign m1_ack   = busy_ok &&  grant_p1;
  assign m0_rdata = mem_rdata;
  assign m1_rdata = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
//   Directed bench for mem_arbiter.
//   - Instance a: round-robin arbitration (PRIO_FIXED=0).
//   - Instance b: fixed priority to port 0 (PRIO_FIXED=1).
//   Each instance has a simple registered memory. It returns
//   32'hC0DE0000 | word_index for a strobed read.
module tb_mem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  logic [31:0] a_m0_addr, a_m0_wdata, a_m0_rdata;
  logic [31:0] a_m1_addr, a_m1_wdata, a_m1_rdata;
  logic [3:0]  a_m0_wmask, a_m1_wmask;
  logic        a_m0_req, a_m0_ack, a_m1_req, a_m1_ack;
  logic [31:0] a_mem_addr, a_mem_wdata, a_mem_rdata;
  logic        a_mem_rstrb;
  logic [3:0]  a_mem_wmask;

  logic [31:0] b_m0_addr, b_m0_wdata, b_m0_rdata;
  logic [31:0] b_m1_addr, b_m1_wdata, b_m1_rdata;
  logic [3:0]  b_m0_wmask, b_m1_wmask;
  logic        b_m0_req, b_m0_ack, b_m1_req, b_m1_ack;
  logic [31:0] b_mem_addr, b_mem_wdata, b_mem_rdata;
  logic        b_mem_rstrb;
  logic [3:0]  b_mem_wmask;

  int checks = 0;
  int errors = 0;

  mem_arbiter #(.ADDR_WIDTH(32), .PRIO_FIXED(1'b0)) dut_a (
    .clk(clk), .reset(reset),
    .m0_addr(a_m0_addr), .m0_wdata(a_m0_wdata), .m0_wmask(a_m0_wmask),
    .m0_req(a_m0_req), .m0_ack(a_m0_ack), .m0_rdata(a_m0_rdata),
    .m1_addr(a_m1_addr), .m1_wdata(a_m1_wdata), .m1_wmask(a_m1_wmask),
    .m1_req(a_m1_req), .m1_ack(a_m1_ack), .m1_rdata(a_m1_rdata),
    .mem_addr(a_mem_addr), .mem_rstrb(a_mem_rstrb), .mem_wdata(a_mem_wdata),
    .mem_wmask(a_mem_wmask), .mem_rdata(a_mem_rdata)
  );

  mem_arbiter #(.ADDR_WIDTH(32), .PRIO_FIXED(1'b1)) dut_b (
    .clk(clk), .reset(reset),
    .m0_addr(b_m0_addr), .m0_wdata(b_m0_wdata), .m0_wmask(b_m0_wmask),
    .m0_req(b_m0_req), .m0_ack(b_m0_ack), .m0_rdata(b_m0_rdata),
    .m1_addr(b_m1_addr), .m1_wdata(b_m1_wdata), .m1_wmask(b_m1_wmask),
    .m1_req(b_m1_req), .m1_ack(b_m1_ack), .m1_rdata(b_m1_rdata),
    .mem_addr(b_mem_addr), .mem_rstrb(b_mem_rstrb), .mem_wdata(b_mem_wdata),
    .mem_wmask(b_mem_wmask), .mem_rdata(b_mem_rdata)
  );

  // Registered-read memory models
  always @(posedge clk) begin
    if (a_mem_rstrb) a_mem_rdata <= 32'hC0DE0000 | {26'd0, a_mem_addr[7:2]};
    if (b_mem_rstrb) b_mem_rdata <= 32'hC0DE0000 | {26'd0, b_mem_addr[7:2]};
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    a_m0_req = 0; a_m1_req = 0; b_m0_req = 0; b_m1_req = 0;
    a_m0_wmask = 0; a_m1_wmask = 0; b_m0_wmask = 0; b_m1_wmask = 0;
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    a_m0_addr = 32'h0; a_m1_addr = 32'h0; a_m0_wdata = 0; a_m1_wdata = 0;
    b_m0_addr = 32'h0; b_m1_addr = 32'h20; b_m0_wdata = 0; b_m1_wdata = 0;
    a_m0_req = 0; a_m1_req = 0; b_m0_req = 0; b_m1_req = 0;
    a_m0_wmask = 0; a_m1_wmask = 0; b_m0_wmask = 0; b_m1_wmask = 0;
    reset = 1'b1;
    step();
    @(negedge clk);
    checks++; if (a_m0_ack !== 1'b0) begin errors++; $display("FAIL reset_m0_ack got %b want 0", a_m0_ack); end
    checks++; if (a_m1_ack !== 1'b0) begin errors++; $display("FAIL reset_m1_ack got %b want 0", a_m1_ack); end
    checks++; if (a_mem_rstrb !== 1'b0) begin errors++; $display("FAIL reset_rstrb got %b want 0", a_mem_rstrb); end
    checks++; if (a_mem_wmask !== 4'b0) begin errors++; $display("FAIL reset_wmask got %b want 0000", a_mem_wmask); end
    step();
    reset = 1'b0;
  endtask

  task automatic test_read_port0();
    do_reset();
    a_m0_addr = 32'h10; a_m0_wmask = 4'b0; a_m0_req = 1;
    @(negedge clk);
    checks++; if (a_mem_addr !== 32'h10) begin errors++; $display("FAIL rd0_addr got %h want 00000010", a_mem_addr); end
    checks++; if (a_mem_rstrb !== 1'b1) begin errors++; $display("FAIL rd0_rstrb got %b want 1", a_mem_rstrb); end
    checks++; if (a_m0_ack !== 1'b0) begin errors++; $display("FAIL rd0_early_ack got %b want 0", a_m0_ack); end
    step();
    a_m0_req = 0;
    @(negedge clk);
    checks++; if (a_m0_ack !== 1'b1) begin errors++; $display("FAIL rd0_ack got %b want 1", a_m0_ack); end
    checks++; if (a_m0_rdata !== 32'hC0DE0004) begin errors++; $display("FAIL rd0_rdata got %h want c0de0004", a_m0_rdata); end
    checks++; if (a_m1_ack !== 1'b0) begin errors++; $display("FAIL rd0_m1_ack got %b want 0", a_m1_ack); end
    checks++; if (a_mem_rstrb !== 1'b0) begin errors++; $display("FAIL rd0_busy_rstrb got %b want 0", a_mem_rstrb); end
    step();
  endtask

  task automatic test_tie();
    do_reset();
    a_m0_addr = 32'h0; a_m1_addr = 32'h20; a_m0_wmask = 0; a_m1_wmask = 0;
    a_m0_req = 1; a_m1_req = 1;
    @(negedge clk);
    checks++; if (a_mem_addr !== 32'h0) begin errors++; $display("FAIL tie_t0_addr got %h want 00000000", a_mem_addr); end
    step();
    @(negedge clk);
    checks++; if (a_m0_ack !== 1'b1 || a_m1_ack !== 1'b0) begin errors++; $display("FAIL tie_t1_acks got %b%b want 10", a_m0_ack, a_m1_ack); end
    checks++; if (a_m0_rdata !== 32'hC0DE0000) begin errors++; $display("FAIL tie_t1_rdata got %h want c0de0000", a_m0_rdata); end
    step();
    a_m0_req = 0;
    @(negedge clk);
    checks++; if (a_mem_addr !== 32'h20 || a_mem_rstrb !== 1'b1) begin errors++; $display("FAIL tie_t2_issue got addr %h rstrb %b want 00000020 1", a_mem_addr, a_mem_rstrb); end
    step();
    @(negedge clk);
    checks++; if (a_m1_ack !== 1'b1 || a_m0_ack !== 1'b0) begin errors++; $display("FAIL tie_t3_acks got %b%b want 01", a_m0_ack, a_m1_ack); end
    checks++; if (a_m1_rdata !== 32'hC0DE0008) begin errors++; $display("FAIL tie_t3_rdata got %h want c0de0008", a_m1_rdata); end
    step();
    a_m1_req = 0;
  endtask

  task automatic test_round_robin();
    logic e0, e1;
    do_reset();
    a_m0_addr = 32'h0; a_m1_addr = 32'h20; a_m0_wmask = 0; a_m1_wmask = 0;
    a_m0_req = 1; a_m1_req = 1;
    for (int c = 0; c < 8; c++) begin
      e0 = (c % 4 == 1);
      e1 = (c % 4 == 3);
      @(negedge clk);
      checks++;
      if (a_m0_ack !== e0 || a_m1_ack !== e1) begin
        errors++;
        $display("FAIL rr_cycle%0d got acks %b%b want %b%b", c, a_m0_ack, a_m1_ack, e0, e1);
      end
      step();
    end
    a_m0_req = 0; a_m1_req = 0;
    step();
  endtask

  task automatic test_write_port1();
    do_reset();
    a_m1_addr = 32'h8; a_m1_wdata = 32'hDEADBEEF; a_m1_wmask = 4'b0011; a_m1_req = 1;
    @(negedge clk);
    checks++; if (a_mem_wmask !== 4'b0011) begin errors++; $display("FAIL wr1_wmask got %b want 0011", a_mem_wmask); end
    checks++; if (a_mem_wdata !== 32'hDEADBEEF) begin errors++; $display("FAIL wr1_wdata got %h want deadbeef", a_mem_wdata); end
    checks++; if (a_mem_rstrb !== 1'b0) begin errors++; $display("FAIL wr1_rstrb got %b want 0", a_mem_rstrb); end
    checks++; if (a_mem_addr !== 32'h8) begin errors++; $display("FAIL wr1_addr got %h want 00000008", a_mem_addr); end
    step();
    a_m1_req = 0;
    @(negedge clk);
    checks++; if (a_m1_ack !== 1'b1 || a_m0_ack !== 1'b0) begin errors++; $display("FAIL wr1_acks got %b%b want 01", a_m0_ack, a_m1_ack); end
    checks++; if (a_mem_wmask !== 4'b0) begin errors++; $display("FAIL wr1_busy_wmask got %b want 0000", a_mem_wmask); end
    step();
    a_m1_wmask = 0;
  endtask

  task automatic test_reset_busy();
    do_reset();
    a_m0_addr = 32'hC; a_m0_wmask = 0; a_m0_req = 1;
    step();
    reset = 1'b1;
    a_m0_req = 0;
    @(negedge clk);
    checks++; if (a_m0_ack !== 1'b0 || a_m1_ack !== 1'b0) begin errors++; $display("FAIL rstbusy_acks got %b%b want 00", a_m0_ack, a_m1_ack); end
    step();
    reset = 1'b0;
    @(negedge clk);
    checks++; if (a_m0_ack !== 1'b0 || a_m1_ack !== 1'b0) begin errors++; $display("FAIL rstbusy_after_acks got %b%b want 00", a_m0_ack, a_m1_ack); end
    step();
    a_m0_addr = 32'h4; a_m0_req = 1;
    @(negedge clk);
    checks++; if (a_mem_addr !== 32'h4 || a_mem_rstrb !== 1'b1) begin errors++; $display("FAIL rstbusy_issue got addr %h rstrb %b want 00000004 1", a_mem_addr, a_mem_rstrb); end
    step();
    a_m0_req = 0;
    @(negedge clk);
    checks++; if (a_m0_ack !== 1'b1) begin errors++; $display("FAIL rstbusy_ack got %b want 1", a_m0_ack); end
    checks++; if (a_m0_rdata !== 32'hC0DE0001) begin errors++; $display("FAIL rstbusy_rdata got %h want c0de0001", a_m0_rdata); end
    step();
  endtask

  task automatic test_fixed_prio();
    logic e0;
    do_reset();
    b_m0_addr = 32'h0; b_m1_addr = 32'h20; b_m0_wmask = 0; b_m1_wmask = 0;
    b_m0_req = 1; b_m1_req = 1;
    for (int c = 0; c < 8; c++) begin
      e0 = (c % 2 == 1);
      @(negedge clk);
      checks++;
      if (b_m0_ack !== e0 || b_m1_ack !== 1'b0) begin
        errors++;
        $display("FAIL fixed_cycle%0d got acks %b%b want %b0", c, b_m0_ack, b_m1_ack, e0);
      end
      if (!e0) begin
        checks++;
        if (b_mem_addr !== 32'h0) begin errors++; $display("FAIL fixed_addr%0d got %h want 00000000", c, b_mem_addr); end
      end else begin
        checks++;
        if (b_m0_rdata !== 32'hC0DE0000) begin errors++; $display("FAIL fixed_rdata%0d got %h want c0de0000", c, b_m0_rdata); end
      end
      step();
    end
    b_m0_req = 0; b_m1_req = 0;
    step();
  endtask

  initial begin
    test_reset();
    test_read_port0();
    test_tie();
    test_round_robin();
    test_write_port1();
    test_reset_busy();
    test_fixed_prio();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
